// File: rtl/ex_unit_if.sv
// Shared op encoding and result type, plus the issue/CDB bundle
// between the reservation station, ex_unit and the ROB.
package ex_pkg;

  typedef logic [5:0] op_t;

  localparam op_t OP_ADD    = 6'd1;
  localparam op_t OP_SUB    = 6'd2;
  localparam op_t OP_AND    = 6'd3;
  localparam op_t OP_OR     = 6'd4;
  localparam op_t OP_XOR    = 6'd5;
  localparam op_t OP_SLL    = 6'd6;
  localparam op_t OP_SRL    = 6'd7;
  localparam op_t OP_SRA    = 6'd8;
  localparam op_t OP_SLT    = 6'd9;
  localparam op_t OP_SLTU   = 6'd10;
  localparam op_t OP_ADDI   = 6'd11;
  localparam op_t OP_ANDI   = 6'd12;
  localparam op_t OP_ORI    = 6'd13;
  localparam op_t OP_XORI   = 6'd14;
  localparam op_t OP_SLLI   = 6'd15;
  localparam op_t OP_SRLI   = 6'd16;
  localparam op_t OP_SRAI   = 6'd17;
  localparam op_t OP_SLTI   = 6'd18;
  localparam op_t OP_SLTIU  = 6'd19;
  localparam op_t OP_LUI    = 6'd20;
  localparam op_t OP_AUIPC  = 6'd21;
  localparam op_t OP_JAL    = 6'd22;
  localparam op_t OP_JALR   = 6'd23;
  localparam op_t OP_BEQ    = 6'd24;
  localparam op_t OP_BNE    = 6'd25;
  localparam op_t OP_BLT    = 6'd26;
  localparam op_t OP_BGE    = 6'd27;
  localparam op_t OP_BLTU   = 6'd28;
  localparam op_t OP_BGEU   = 6'd29;
  localparam op_t OP_MUL    = 6'd30;
  localparam op_t OP_MULH   = 6'd31;
  localparam op_t OP_MULHSU = 6'd32;
  localparam op_t OP_MULHU  = 6'd33;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        jump;
    logic [31:0] target;
  } cdb_t;

endpackage

interface ex_unit_if;

  logic              issue_valid;
  logic              issue_ready;
  ex_pkg::op_t       op_type;
  logic [31:0]       data_rs1;
  logic [31:0]       data_rs2;
  logic [31:0]       imm;
  logic [31:0]       pc;
  logic [3:0]        tag_in_rob;
  logic              cdb_valid;
  logic              cdb_grant;
  logic [3:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic              cdb_jump;
  logic [31:0]       cdb_target;

  modport master (
    output issue_valid, op_type,
    output data_rs1, data_rs2,
    output imm, pc, tag_in_rob,
    output cdb_grant,
    input  issue_ready,
    input  cdb_valid, cdb_tag,
    input  cdb_data, cdb_jump,
    input  cdb_target
  );

  modport slave (
    input  issue_valid, op_type,
    input  data_rs1, data_rs2,
    input  imm, pc, tag_in_rob,
    input  cdb_grant,
    output issue_ready,
    output cdb_valid, cdb_tag,
    output cdb_data, cdb_jump,
    output cdb_target
  );

endinterface

// File: rtl/ex_unit.sv
// Integer execute unit: 1-cycle ALU into a 2-entry CDB result queue.
// Define EX_MUL_EN to add the 3-cycle M-extension multiplier FSM.
module ex_unit
  import ex_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     clear,
  ex_unit_if.slave bus
);

  cdb_t       q0_q, q0_d;
  cdb_t       q1_q, q1_d;
  logic [1:0] cnt_q, cnt_d;

  cdb_t        alu_res;
  cdb_t        mul_res;
  cdb_t        push_res;
  logic        is_mul;
  logic        busy;
  logic        mul_push;
  logic        issue_ready;
  logic        accept;
  logic        alu_push;
  logic        push;
  logic        deq;
  logic        is_imm;
  logic        is_br;
  logic        take;
  logic [1:0]  wpos;
  logic [31:0] opb;
  logic [4:0]  shamt;

  assign issue_ready = (cnt_q != 2'd2) && !busy;
  assign accept      = bus.issue_valid && issue_ready
                     && rdy && !clear;
  assign alu_push    = accept && !is_mul;
  assign deq         = bus.cdb_grant && (cnt_q != 2'd0);
  assign push        = alu_push || mul_push;
  assign push_res    = mul_push ? mul_res : alu_res;

  assign is_imm = bus.op_type inside {
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
    OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU
  };
  assign is_br = bus.op_type inside {
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  };

  always_comb begin
    alu_res     = '0;
    alu_res.tag = bus.tag_in_rob;
    take        = 1'b0;
    opb         = is_imm ? bus.imm : bus.data_rs2;
    shamt       = opb[4:0];
    unique case (bus.op_type)
      OP_ADD, OP_ADDI:
        alu_res.data = bus.data_rs1 + opb;
      OP_SUB:
        alu_res.data = bus.data_rs1 - bus.data_rs2;
      OP_AND, OP_ANDI:
        alu_res.data = bus.data_rs1 & opb;
      OP_OR, OP_ORI:
        alu_res.data = bus.data_rs1 | opb;
      OP_XOR, OP_XORI:
        alu_res.data = bus.data_rs1 ^ opb;
      OP_SLL, OP_SLLI:
        alu_res.data = bus.data_rs1 << shamt;
      OP_SRL, OP_SRLI:
        alu_res.data = bus.data_rs1 >> shamt;
      OP_SRA, OP_SRAI:
        alu_res.data = $signed(bus.data_rs1) >>> shamt;
      OP_SLT, OP_SLTI:
        alu_res.data = {31'b0,
          $signed(bus.data_rs1) < $signed(opb)};
      OP_SLTU, OP_SLTIU:
        alu_res.data = {31'b0, bus.data_rs1 < opb};
      OP_LUI:
        alu_res.data = bus.imm;
      OP_AUIPC:
        alu_res.data = bus.pc + bus.imm;
      OP_JAL: begin
        alu_res.data   = bus.pc + 32'd4;
        alu_res.jump   = 1'b1;
        alu_res.target = bus.pc + bus.imm;
      end
      OP_JALR: begin
        alu_res.data   = bus.pc + 32'd4;
        alu_res.jump   = 1'b1;
        alu_res.target = (bus.data_rs1 + bus.imm)
                       & 32'hFFFF_FFFE;
      end
      OP_BEQ:  take = bus.data_rs1 == bus.data_rs2;
      OP_BNE:  take = bus.data_rs1 != bus.data_rs2;
      OP_BLT:
        take = $signed(bus.data_rs1) < $signed(bus.data_rs2);
      OP_BGE:
        take = $signed(bus.data_rs1) >= $signed(bus.data_rs2);
      OP_BLTU: take = bus.data_rs1 <  bus.data_rs2;
      OP_BGEU: take = bus.data_rs1 >= bus.data_rs2;
      default: ;
    endcase
    if (is_br) begin
      alu_res.jump   = take;
      alu_res.target = take ? bus.pc + bus.imm : '0;
    end
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE, S_M1, S_M2, S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] ma_q, ma_d;
  logic [63:0] mb_q, mb_d;
  logic [63:0] prod_q, prod_d;
  logic        mhi_q, mhi_d;
  logic [3:0]  mtag_q, mtag_d;
  logic        sa, sb;

  assign is_mul = bus.op_type inside {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
  };
  assign busy = state_q != S_IDLE;

  // Operands are pre-extended to 64 bits so a plain
  // modulo-2^64 product gives every high-half variant.
  always_comb begin
    state_d      = state_q;
    ma_d         = ma_q;
    mb_d         = mb_q;
    prod_d       = prod_q;
    mhi_d        = mhi_q;
    mtag_d       = mtag_q;
    mul_push     = 1'b0;
    mul_res      = '0;
    mul_res.tag  = mtag_q;
    mul_res.data = mhi_q ? prod_q[63:32] : prod_q[31:0];
    sa = bus.op_type inside {OP_MULH, OP_MULHSU};
    sb = bus.op_type == OP_MULH;
    unique case (state_q)
      S_IDLE:
        if (accept && is_mul) begin
          ma_d = {{32{sa & bus.data_rs1[31]}},
                  bus.data_rs1};
          mb_d = {{32{sb & bus.data_rs2[31]}},
                  bus.data_rs2};
          mhi_d   = bus.op_type != OP_MUL;
          mtag_d  = bus.tag_in_rob;
          state_d = S_M1;
        end
      S_M1: begin
        prod_d  = ma_q * mb_q;
        state_d = S_M2;
      end
      S_M2:
        if (cnt_q != 2'd2) begin
          mul_push = 1'b1;
          state_d  = S_WB;
        end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= S_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      prod_q  <= '0;
      mhi_q   <= 1'b0;
      mtag_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      prod_q  <= prod_d;
      mhi_q   <= mhi_d;
      mtag_q  <= mtag_d;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_push = 1'b0;
  assign mul_res  = '0;
`endif

  // Shift-style FIFO: q0 is always the head.
  always_comb begin
    q0_d  = q0_q;
    q1_d  = q1_q;
    wpos  = cnt_q - {1'b0, deq};
    cnt_d = cnt_q + {1'b0, push} - {1'b0, deq};
    if (deq) q0_d = q1_q;
    if (push) begin
      if (wpos == 2'd0) q0_d = push_res;
      else              q1_d = push_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q0_q  <= '0;
      q1_q  <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      q0_q  <= q0_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.cdb_valid   = cnt_q != 2'd0;
  assign bus.cdb_tag     = bus.cdb_valid ? q0_q.tag : '0;
  assign bus.cdb_data    = bus.cdb_valid ? q0_q.data : '0;
  assign bus.cdb_jump    = bus.cdb_valid && q0_q.jump;
  assign bus.cdb_target  = bus.cdb_valid ? q0_q.target : '0;

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit with an in-bench queue model
// checked every cycle plus hand-computed literal pins.
module tb_ex_unit;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, clear;
  always #5 clk = ~clk;

  ex_unit_if bus();

  ex_unit dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        jump;
    logic [31:0] target;
  } res_t;

  function automatic res_t ref_op(op_t op,
      logic [31:0] a, logic [31:0] b, logic [31:0] i,
      logic [31:0] pc, logic [3:0] tag);
    res_t r;
    logic [63:0] p;
    bit t;
    r.tag = tag; r.data = 0; r.jump = 0; r.target = 0;
    t = 0;
    p = 0;
    case (op)
      OP_ADD:   r.data = a + b;
      OP_ADDI:  r.data = a + i;
      OP_SUB:   r.data = a - b;
      OP_AND:   r.data = a & b;
      OP_ANDI:  r.data = a & i;
      OP_OR:    r.data = a | b;
      OP_ORI:   r.data = a | i;
      OP_XOR:   r.data = a ^ b;
      OP_XORI:  r.data = a ^ i;
      OP_SLL:   r.data = a << b[4:0];
      OP_SLLI:  r.data = a << i[4:0];
      OP_SRL:   r.data = a >> b[4:0];
      OP_SRLI:  r.data = a >> i[4:0];
      OP_SRA:   r.data = $signed(a) >>> b[4:0];
      OP_SRAI:  r.data = $signed(a) >>> i[4:0];
      OP_SLT:
        r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTI:
        r.data = ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
      OP_SLTU:  r.data = (a < b) ? 32'd1 : 32'd0;
      OP_SLTIU: r.data = (a < i) ? 32'd1 : 32'd0;
      OP_LUI:   r.data = i;
      OP_AUIPC: r.data = pc + i;
      OP_JAL: begin
        r.data = pc + 4; r.jump = 1; r.target = pc + i;
      end
      OP_JALR: begin
        r.data = pc + 4; r.jump = 1;
        r.target = (a + i) & 32'hFFFF_FFFE;
      end
      OP_BEQ:  t = (a == b);
      OP_BNE:  t = (a != b);
      OP_BLT:  t = ($signed(a) < $signed(b));
      OP_BGE:  t = ($signed(a) >= $signed(b));
      OP_BLTU: t = (a < b);
      OP_BGEU: t = (a >= b);
`ifdef EX_MUL_EN
      OP_MUL: r.data = a * b;
      OP_MULH: begin
        p = longint'($signed(a)) * longint'($signed(b));
        r.data = p[63:32];
      end
      OP_MULHSU: begin
        p = longint'($signed(a)) * longint'({32'b0, b});
        r.data = p[63:32];
      end
      OP_MULHU: begin
        p = {32'b0, a} * {32'b0, b};
        r.data = p[63:32];
      end
`endif
      default: ;
    endcase
    if (op inside {OP_BEQ, OP_BNE, OP_BLT,
                   OP_BGE, OP_BLTU, OP_BGEU}) begin
      r.jump = t;
      r.target = t ? pc + i : 32'd0;
    end
    return r;
  endfunction

  function automatic bit is_mul_op(op_t op);
`ifdef EX_MUL_EN
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
`else
    return 1'b0;
`endif
  endfunction

  // Model: results in acceptance order; a multiply sits in
  // mstage 1..3 (issue blocked) and joins the queue leaving 2.
  res_t       mq[$];
  res_t       mpend;
  int         mstage = 0;
  bit         chk_en = 0;
  bit         m_rdy, m_acc, m_deq, m_mpush;
  logic [3:0] pops[$];

  always @(posedge clk) begin
    if (rst || clear) begin
      mq.delete();
      mstage = 0;
    end else if (rdy) begin
      m_rdy   = (mq.size() < 2) && (mstage == 0);
      m_acc   = bus.issue_valid && m_rdy;
      m_deq   = bus.cdb_grant && (mq.size() > 0);
      m_mpush = (mstage == 2) && (mq.size() < 2);
      if (m_deq) void'(mq.pop_front());
      if (mstage == 1)      mstage = 2;
      else if (m_mpush) begin
        mq.push_back(mpend);
        mstage = 3;
      end
      else if (mstage == 3) mstage = 0;
      if (m_acc) begin
        if (is_mul_op(bus.op_type)) begin
          mpend = ref_op(bus.op_type, bus.data_rs1,
                    bus.data_rs2, bus.imm, bus.pc,
                    bus.tag_in_rob);
          mstage = 1;
        end else begin
          mq.push_back(ref_op(bus.op_type, bus.data_rs1,
                         bus.data_rs2, bus.imm, bus.pc,
                         bus.tag_in_rob));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issue_ready", 32'(bus.issue_ready),
          32'((mq.size() < 2) && (mstage == 0)));
      chk("cdb_valid", 32'(bus.cdb_valid),
          32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("cdb_tag", 32'(bus.cdb_tag), 32'(mq[0].tag));
        chk("cdb_data", bus.cdb_data, mq[0].data);
        chk("cdb_jump", 32'(bus.cdb_jump),
            32'(mq[0].jump));
        chk("cdb_target", bus.cdb_target, mq[0].target);
      end
      if (bus.cdb_valid && bus.cdb_grant)
        pops.push_back(bus.cdb_tag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.op_type     = '0;
    bus.data_rs1    = '0;
    bus.data_rs2    = '0;
    bus.imm         = '0;
    bus.pc          = '0;
    bus.tag_in_rob  = '0;
  endtask

  task automatic drive(op_t op, logic [31:0] a,
      logic [31:0] b, logic [31:0] i, logic [31:0] pc,
      logic [3:0] tag);
    bus.issue_valid = 1'b1;
    bus.op_type     = op;
    bus.data_rs1    = a;
    bus.data_rs2    = b;
    bus.imm         = i;
    bus.pc          = pc;
    bus.tag_in_rob  = tag;
  endtask

  typedef struct packed {
    op_t         op;
    logic [31:0] a, b, i, pc;
    logic [31:0] data;
    logic        jump;
    logic [31:0] target;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV] = '{
    '{OP_BLT,   32'hFFFFFFFF, 32'h0, 32'h20, 32'h100,
      32'h0, 1'b1, 32'h120},
    '{OP_BLTU,  32'hFFFFFFFF, 32'h0, 32'h20, 32'h100,
      32'h0, 1'b0, 32'h0},
    '{OP_JALR,  32'h1003, 32'h0, 32'h4, 32'h40,
      32'h44, 1'b1, 32'h1006},
    '{OP_SUB,   32'h5, 32'h7, 32'h0, 32'h0,
      32'hFFFFFFFE, 1'b0, 32'h0},
    '{OP_SRA,   32'h80000000, 32'h24, 32'h0, 32'h0,
      32'hF8000000, 1'b0, 32'h0},
    '{OP_SRLI,  32'h80000000, 32'h0, 32'h1F, 32'h0,
      32'h1, 1'b0, 32'h0},
    '{OP_SLL,   32'h1, 32'h21, 32'h0, 32'h0,
      32'h2, 1'b0, 32'h0},
    '{OP_SLTI,  32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
      32'h1, 1'b0, 32'h0},
    '{OP_SLTU,  32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
      32'h0, 1'b0, 32'h0},
    '{OP_XORI,  32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 32'h0,
      32'h0F0F0F0F, 1'b0, 32'h0},
    '{OP_ANDI,  32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 32'h0,
      32'h0F000F00, 1'b0, 32'h0},
    '{OP_OR,    32'h1, 32'h2, 32'h0, 32'h0,
      32'h3, 1'b0, 32'h0},
    '{OP_LUI,   32'h9, 32'h9, 32'h12345000, 32'h0,
      32'h12345000, 1'b0, 32'h0},
    '{OP_AUIPC, 32'h0, 32'h0, 32'hFFFFF000, 32'h1000,
      32'h0, 1'b0, 32'h0},
    '{OP_JAL,   32'h0, 32'h0, 32'hFFFFFFF0, 32'h200,
      32'h204, 1'b1, 32'h1F0},
    '{OP_BEQ,   32'h5, 32'h5, 32'h8, 32'h80,
      32'h0, 1'b1, 32'h88},
    '{OP_BNE,   32'h5, 32'h5, 32'h8, 32'h80,
      32'h0, 1'b0, 32'h0},
    '{OP_BGE,   32'h0, 32'hFFFFFFFF, 32'h8, 32'h80,
      32'h0, 1'b1, 32'h88},
    '{6'd63,    32'h1234, 32'h5678, 32'h9, 32'h80,
      32'h0, 1'b0, 32'h0}
  };

  task automatic lit(string n, vec_t v);
    chk({n, "_valid"}, 32'(bus.cdb_valid), 32'd1);
    chk({n, "_data"}, bus.cdb_data, v.data);
    chk({n, "_jump"}, 32'(bus.cdb_jump), 32'(v.jump));
    chk({n, "_target"}, bus.cdb_target, v.target);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; rdy = 1'b1;
    bus.cdb_grant = 1'b0;
    idle();
    step();
    chk_en = 1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_tag", 32'(bus.cdb_tag), 32'd0);
    chk("rst_data", bus.cdb_data, 32'd0);
    chk("rst_jump", 32'(bus.cdb_jump), 32'd0);
    chk("rst_target", bus.cdb_target, 32'd0);
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    step();
    rst = 1'b0;
    bus.cdb_grant = 1'b1;

    drive(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 4'd3);
    step();
    idle();
    @(negedge clk);
    chk("add_valid", 32'(bus.cdb_valid), 32'd1);
    chk("add_tag", 32'(bus.cdb_tag), 32'd3);
    chk("add_data", bus.cdb_data, 32'h80000000);
    chk("add_jump", 32'(bus.cdb_jump), 32'd0);
    #1;

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].op, vecs[k].a, vecs[k].b,
            vecs[k].i, vecs[k].pc, 4'(k % 15 + 1));
      step();
      idle();
      @(negedge clk);
      lit($sformatf("vec%0d", k), vecs[k]);
      #1;
    end

`ifndef EX_MUL_EN
    drive(OP_MUL, 32'h3, 32'h5, 32'h0, 32'h0, 4'd2);
    step();
    idle();
    @(negedge clk);
    chk("nomul_data", bus.cdb_data, 32'd0);
    chk("nomul_valid", 32'(bus.cdb_valid), 32'd1);
    #1;
`endif

    drive(OP_JALR, 32'h1003, 32'h0, 32'h4, 32'h40, 4'd6);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("clr_novalid", 32'(bus.cdb_valid), 32'd0);
      step();
    end

    bus.cdb_grant = 1'b0;
    pops.delete();
    drive(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 4'd5);
    step();
    drive(OP_SUB, 32'h9, 32'h1, 32'h0, 32'h0, 4'd6);
    step();
    @(negedge clk);
    chk("full_ready", 32'(bus.issue_ready), 32'd0);
    chk("full_head", 32'(bus.cdb_tag), 32'd5);
    #1;
    drive(OP_XOR, 32'hF, 32'h3, 32'h0, 32'h0, 4'd7);
    step();
    step();
    bus.cdb_grant = 1'b1;
    step();
    step();
    idle();
    @(negedge clk);
    chk("enq_deq_head", 32'(bus.cdb_tag), 32'd7);
    step();
    step();
    chk("pops_n", pops.size(), 32'd3);
    if (pops.size() == 3) begin
      chk("pop0", 32'(pops[0]), 32'd5);
      chk("pop1", 32'(pops[1]), 32'd6);
      chk("pop2", 32'(pops[2]), 32'd7);
    end

    bus.cdb_grant = 1'b0;
    drive(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 4'd9);
    step();
    rdy = 1'b0;
    bus.cdb_grant = 1'b1;
    drive(OP_ADD, 32'h2, 32'h2, 32'h0, 32'h0, 4'd10);
    step();
    step();
    @(negedge clk);
    chk("hold_valid", 32'(bus.cdb_valid), 32'd1);
    chk("hold_tag", 32'(bus.cdb_tag), 32'd9);
    chk("hold_data", bus.cdb_data, 32'd2);
    #1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    rdy = 1'b1;
    idle();
    @(negedge clk);
    chk("clr_rdy0_valid", 32'(bus.cdb_valid), 32'd0);
    chk("clr_rdy0_ready", 32'(bus.issue_ready), 32'd1);
    #1;

`ifdef EX_MUL_EN
    drive(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h0, 32'h0, 4'd4);
    step();
    idle();
    @(negedge clk);
    chk("mul_ready_m1", 32'(bus.issue_ready), 32'd0);
    step();
    @(negedge clk);
    chk("mul_ready_m2", 32'(bus.issue_ready), 32'd0);
    chk("mul_early", 32'(bus.cdb_valid), 32'd0);
    step();
    @(negedge clk);
    chk("mulhu_valid", 32'(bus.cdb_valid), 32'd1);
    chk("mulhu_tag", 32'(bus.cdb_tag), 32'd4);
    chk("mulhu_data", bus.cdb_data, 32'hFFFFFFFE);
    step();
    step();

    drive(OP_MUL, 32'h3, 32'h5, 32'h0, 32'h0, 4'd8);
    step();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("mulclr_ready", 32'(bus.issue_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("mulclr_novalid", 32'(bus.cdb_valid), 32'd0);
    end
    #1;

    drive(OP_MUL, 32'h3, 32'h5, 32'h0, 32'h0, 4'd1);
    step(); idle(); step(); step();
    @(negedge clk);
    chk("mul_data", bus.cdb_data, 32'd15);
    step(); step();
    drive(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h0, 32'h0, 4'd2);
    step(); idle(); step(); step();
    @(negedge clk);
    chk("mulh_data", bus.cdb_data, 32'd0);
    step(); step();
    drive(OP_MULHSU, 32'hFFFFFFFF, 32'h2,
          32'h0, 32'h0, 4'd3);
    step(); idle(); step(); step();
    @(negedge clk);
    chk("mulhsu_data", bus.cdb_data, 32'hFFFFFFFF);
    step(); step();
`endif

    step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
